// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared constants for the two-requester FIFO write-port arbiter.
package fifo_wr_arbiter_pkg;

  // FSM state encoding
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_WRITE = 1'b1;

  // Requester indices
  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  // Round-robin pick: on contention the side that did not win last time goes next,
  // otherwise whichever side is requesting.
  function automatic logic rr_pick(input logic req0, input logic req1, input logic last);
    return (req0 && req1) ? ~last : req1;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between two req/ack requesters.
// Every write is followed by an IDLE cycle so that `full` reflects the last write
// before the next grant is considered.
module fifo_wr_arbiter
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int unsigned B = 8,
  parameter int unsigned C = 8
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         req0_i,
  input  logic [B-1:0] data0_i,
  output logic         ack0_o,
  input  logic         req1_i,
  input  logic [B-1:0] data1_i,
  output logic         ack1_o,
  input  logic         full_i,
  output logic         wr_o,
  output logic [B-1:0] w_data_o,
  output logic         busy_o,
  output logic         last_grant_o,
  output logic [C-1:0] wr_count_o
);

  logic [0:0]   state_q, state_d;
  logic         wr_q, wr_d;
  logic         ack0_q, ack0_d;
  logic         ack1_q, ack1_d;
  logic [B-1:0] w_data_q, w_data_d;
  logic         last_q, last_d;
  logic [C-1:0] cnt_q, cnt_d;

  logic grant_valid;
  logic grant_idx;

  // Grant decision and next-state logic
  always_comb begin
    grant_valid = !full_i && (req0_i || req1_i);
    grant_idx   = rr_pick(req0_i, req1_i, last_q);

    state_d  = state_q;
    wr_d     = 1'b0;
    ack0_d   = 1'b0;
    ack1_d   = 1'b0;
    w_data_d = w_data_q;
    last_d   = last_q;
    cnt_d    = cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (grant_valid) begin
          state_d  = ST_WRITE;
          wr_d     = 1'b1;
          ack0_d   = (grant_idx == REQ0);
          ack1_d   = (grant_idx == REQ1);
          w_data_d = (grant_idx == REQ1) ? data1_i : data0_i;
          last_d   = grant_idx;
        end
      end
      ST_WRITE: begin
        // The FIFO commits the word on this edge; count it here.
        state_d = ST_IDLE;
        cnt_d   = cnt_q + C'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; reset clears strobes immediately, even mid-write
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= ST_IDLE;
      wr_q     <= 1'b0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      w_data_q <= '0;
      last_q   <= REQ1;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      wr_q     <= wr_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      w_data_q <= w_data_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
    end
  end

  assign wr_o         = wr_q;
  assign ack0_o       = ack0_q;
  assign ack1_o       = ack1_q;
  assign w_data_o     = w_data_q;
  assign busy_o       = (state_q == ST_WRITE);
  assign last_grant_o = last_q;
  assign wr_count_o   = cnt_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: directed scenarios plus a randomized run
// against a rule-level reference model. A second instance with C = 3 checks counter wrap.
module tb_fifo_wr_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       req0, req1, full;
  logic [7:0] data0, data1;

  logic       ack0, ack1, wr, busy, last_grant;
  logic [7:0] w_data, wr_count;
  logic       ack0_c3, ack1_c3, wr_c3, busy_c3, last_grant_c3;
  logic [7:0] w_data_c3;
  logic [2:0] wr_count_c3;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.B(8), .C(8)) dut (
    .clk_i(clk), .reset_i(reset),
    .req0_i(req0), .data0_i(data0), .ack0_o(ack0),
    .req1_i(req1), .data1_i(data1), .ack1_o(ack1),
    .full_i(full), .wr_o(wr), .w_data_o(w_data),
    .busy_o(busy), .last_grant_o(last_grant), .wr_count_o(wr_count)
  );

  fifo_wr_arbiter #(.B(8), .C(3)) dut_c3 (
    .clk_i(clk), .reset_i(reset),
    .req0_i(req0), .data0_i(data0), .ack0_o(ack0_c3),
    .req1_i(req1), .data1_i(data1), .ack1_o(ack1_c3),
    .full_i(full), .wr_o(wr_c3), .w_data_o(w_data_c3),
    .busy_o(busy_c3), .last_grant_o(last_grant_c3), .wr_count_o(wr_count_c3)
  );

  // Reset pulse; returns at posedge+1 with reset released and inputs idle.
  task automatic do_reset();
    reset = 1'b1; req0 = 1'b0; req1 = 1'b0; full = 1'b0; data0 = '0; data1 = '0;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [12:0] got;
    reset = 1'b1; req0 = 1'b1; req1 = 1'b1; data0 = 8'hFF; data1 = 8'hEE; full = 1'b0;
    #1;
    got = {wr, ack0, ack1, busy, last_grant, w_data};
    checks++;
    if (got !== {5'b00001, 8'h00}) $display("FAIL reset_state: got %b want %b", got, {5'b00001, 8'h00});
    else passed++;
    checks++;
    if (wr_count !== 8'd0 || wr_count_c3 !== 3'd0)
      $display("FAIL reset_count: got %0d/%0d want 0/0", wr_count, wr_count_c3);
    else passed++;
    do_reset();
  endtask

  task automatic test_single();
    do_reset();
    req0 = 1'b1; data0 = 8'hA5;
    @(posedge clk); #1;
    checks++;
    if ({wr, ack0, ack1, busy, last_grant, w_data} !== {5'b11010, 8'hA5})
      $display("FAIL single_grant: got wr=%b ack0=%b ack1=%b busy=%b lg=%b wd=%h want 1 1 0 1 0 a5",
               wr, ack0, ack1, busy, last_grant, w_data);
    else passed++;
    req0 = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (wr !== 1'b0 || ack0 !== 1'b0 || wr_count !== 8'd1)
      $display("FAIL single_after: got wr=%b ack0=%b cnt=%0d want 0 0 1", wr, ack0, wr_count);
    else passed++;
  endtask

  task automatic test_back_to_back();
    logic [10:0] got, exp;
    do_reset();
    req0 = 1'b1; req1 = 1'b1; data0 = 8'h11; data1 = 8'h22;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (i % 2 == 0) exp = (i % 4 == 0) ? {3'b110, 8'h11} : {3'b101, 8'h22};
      else            exp = {3'b000, w_data};
      got = {wr, ack0, ack1, w_data};
      checks++;
      if (got !== exp) $display("FAIL b2b_cycle%0d: got %h want %h", i, got, exp);
      else passed++;
      if (i == 7) begin req0 = 1'b0; req1 = 1'b0; end
    end
    checks++;
    if (wr_count !== 8'd4) $display("FAIL b2b_count: got %0d want 4", wr_count);
    else passed++;
  endtask

  task automatic test_full_stall();
    do_reset();
    full = 1'b1; req1 = 1'b1; data1 = 8'h3C;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (wr !== 1'b0 || ack1 !== 1'b0 || ack0 !== 1'b0)
        $display("FAIL stall_cycle%0d: got wr=%b ack1=%b want 0 0", i, wr, ack1);
      else passed++;
    end
    full = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({wr, ack0, ack1, w_data} !== {3'b101, 8'h3C})
      $display("FAIL stall_release: got wr=%b ack0=%b ack1=%b wd=%h want 1 0 1 3c",
               wr, ack0, ack1, w_data);
    else passed++;
    req1 = 1'b0;
    @(posedge clk); #1;
  endtask

  // Depth-4 FIFO modelled in the bench; full is driven from its occupancy.
  task automatic fifo_run(input int cycles, inout int fcount, inout int writes, inout logic pend);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      if (pend) begin
        checks++;
        if (fcount >= 4) $display("FAIL fifo_overflow: got push at occupancy %0d want <4", fcount);
        else passed++;
        fcount++;
      end
      #1;
      full = (fcount >= 4);
      pend = wr;
      if (wr) begin writes++; data0 = data0 + 8'd1; end
    end
  endtask

  task automatic test_fifo_attach();
    int   fcount = 0;
    int   writes = 0;
    logic pend = 1'b0;
    do_reset();
    req0 = 1'b1; data0 = 8'h40;
    fifo_run(20, fcount, writes, pend);
    checks++;
    if (writes != 4 || wr_count !== 8'd4)
      $display("FAIL fifo_fill: got writes=%0d cnt=%0d want 4 4", writes, wr_count);
    else passed++;
    fcount--;
    full = 1'b0;
    fifo_run(12, fcount, writes, pend);
    checks++;
    if (writes != 5 || wr_count !== 8'd5)
      $display("FAIL fifo_refill: got writes=%0d cnt=%0d want 5 5", writes, wr_count);
    else passed++;
    req0 = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 1; i <= 9; i++) begin
      req0 = 1'b1; data0 = 8'(i);
      @(posedge clk); #1;
      req0 = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (wr_count_c3 !== 3'(i % 8) || wr_count !== 8'(i))
        $display("FAIL wrap_%0d: got c3=%0d c8=%0d want %0d %0d", i, wr_count_c3, wr_count, i % 8, i);
      else passed++;
    end
  endtask

  task automatic test_reset_during_write();
    do_reset();
    req0 = 1'b1; req1 = 1'b1; data0 = 8'h5A; data1 = 8'hA5;
    @(posedge clk); #1;
    checks++;
    if (wr !== 1'b1 || ack0 !== 1'b1) $display("FAIL rdw_pre: got wr=%b ack0=%b want 1 1", wr, ack0);
    else passed++;
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({wr, ack0, ack1, busy, last_grant} !== 5'b00001 || wr_count !== 8'd0)
      $display("FAIL rdw_drop: got wr=%b ack0=%b ack1=%b busy=%b lg=%b cnt=%0d want 0 0 0 0 1 0",
               wr, ack0, ack1, busy, last_grant, wr_count);
    else passed++;
    #1 reset = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({ack0, ack1, w_data} !== {2'b10, 8'h5A})
      $display("FAIL rdw_first: got ack0=%b ack1=%b wd=%h want 1 0 5a", ack0, ack1, w_data);
    else passed++;
    @(posedge clk);
    @(posedge clk); #1;
    checks++;
    if ({ack0, ack1, w_data} !== {2'b01, 8'hA5})
      $display("FAIL rdw_second: got ack0=%b ack1=%b wd=%h want 0 1 a5", ack0, ack1, w_data);
    else passed++;
    req0 = 1'b0; req1 = 1'b0;
    @(posedge clk); #1;
  endtask

  // Randomized requesters and full against a rule-level model of the arbiter.
  task automatic test_random();
    logic        m_writing = 1'b0, m_ack0 = 1'b0, m_ack1 = 1'b0, m_last = 1'b1;
    logic [7:0]  m_data = 8'h00;
    int unsigned m_cnt = 0;
    logic        g;
    logic [23:0] got, exp;
    int          errs = 0;
    do_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      // Requester behaviour: hold until acked, then maybe re-request with new data.
      if (m_ack0)    begin req0 = 1'($urandom % 2); data0 = 8'($urandom); end
      else if (!req0) begin req0 = ($urandom % 3 == 0); data0 = 8'($urandom); end
      if (m_ack1)    begin req1 = 1'($urandom % 2); data1 = 8'($urandom); end
      else if (!req1) begin req1 = ($urandom % 3 == 0); data1 = 8'($urandom); end
      full = ($urandom % 4 == 0);

      m_ack0 = 1'b0; m_ack1 = 1'b0;
      if (m_writing) begin
        m_writing = 1'b0;
        m_cnt++;
      end else if (!full && (req0 || req1)) begin
        g = (req0 && req1) ? !m_last : req1;
        m_writing = 1'b1;
        m_ack0 = !g; m_ack1 = g;
        m_last = g;
        m_data = g ? data1 : data0;
      end

      @(posedge clk); #1;
      exp = {m_writing, m_ack0, m_ack1, m_writing, m_last, m_data, 8'(m_cnt), 3'(m_cnt % 8)};
      got = {wr, ack0, ack1, busy, last_grant, w_data, wr_count, wr_count_c3};
      checks++;
      if (got !== exp) begin
        if (errs < 10) $display("FAIL random_cycle%0d: got %h want %h", cyc, got, exp);
        errs++;
      end else passed++;
    end
    req0 = 1'b0; req1 = 1'b0; full = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b1; req0 = 1'b0; req1 = 1'b0; full = 1'b0; data0 = '0; data1 = '0;
    #2;
    test_reset();
    test_single();
    test_back_to_back();
    test_full_stall();
    test_fifo_attach();
    test_wrap();
    test_reset_during_write();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Shares the single write port of the team's `fifo` (parameters B/W) between two independent write requesters, for example the UART receiver and a debounced switch/button source.
- Round-robin arbitration with a req/ack handshake per requester.
- Never writes while the FIFO reports full.
- Sits between the requesters and the `fifo` `wr`/`w_data`/`full` pins. Also provides a running count of committed writes for status LEDs or debug.

Parameters:
- B, 8, data word width in bits; must match the attached `fifo` B.
- C, 8, width of the `wr_count` write counter in bits.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- req0  input  1  requester 0 wants to write; held high until ack0.
- data0  input  B  requester 0 word; stable while req0 is high.
- ack0  output  1  one-cycle pulse: the requester 0 word is being written this cycle.
- req1  input  1  requester 1 request; same rules as req0.
- data1  input  B  requester 1 word.
- ack1  output  1  one-cycle pulse for requester 1.
- full  input  1  FIFO full flag, used combinationally.
- wr  output  1  FIFO write strobe, registered.
- w_data  output  B  FIFO write data, registered.
- busy  output  1  high while the FSM is in WRITE.
- last_grant  output  1  index of the most recently granted requester.
- wr_count  output  C  number of words written, modulo 2^C.

Behaviour:
- Reset (asynchronous, immediate) sets:
  - state = IDLE
  - wr = 0, ack0 = ack1 = 0, w_data = 0, busy = 0
  - last_grant = 1, so requester 0 wins the first tie
  - wr_count = 0
- FSM has two states, IDLE and WRITE.
- IDLE:
  - If full = 1 or no req is high: stay in IDLE, no ack, wr stays 0.
  - If exactly one req is high and full = 0: grant that requester.
  - If both reqs are high and full = 0: grant the requester that is NOT last_grant (round-robin).
  - On grant, at the clock edge: w_data <= granted data, wr <= 1, ack_g <= 1, last_grant <= g, state <= WRITE.
- WRITE:
  - wr, ack_g and busy are high for exactly this one cycle.
  - The FIFO samples w_data on the edge that ends WRITE.
  - wr_count increments on that same edge and wraps from 2^C-1 to 0.
  - Next state is unconditionally IDLE; wr and ack return to 0.
- Latency: from req rising (full = 0, no contention) to wr/ack high is 1 cycle.
- Throughput: at most 1 word per 2 cycles. The IDLE cycle between writes lets `full` reflect the previous write, so the arbiter cannot overflow the FIFO.
- Requester rules:
  - A requester may drop req only after seeing ack.
  - A requester that keeps req high after ack is treated as a new request. With the other requester also asserting, the other side wins next.
- Requests while in WRITE are ignored and evaluated in the following IDLE cycle.
- full rising while a request is pending: the request waits with no ack. The grant is issued in the first IDLE cycle with full = 0, and round-robin order is preserved.
- Reset asserted during WRITE: wr and ack drop asynchronously. The word may or may not have been written; the requester must treat a missing ack edge as not written.
- ack0 and ack1 are never high simultaneously. wr = ack0 | ack1 in every cycle.

Decomposition:
- Shared package/header `fifo_arb_defs` holds:
  - state encoding localparams ST_IDLE = 1'b0, ST_WRITE = 1'b1
  - requester index constants REQ0 = 0, REQ1 = 1
- No sub-module is needed. The round-robin pick is a few lines of combinational logic inside the block.

Test Plan:
- Reset release, req0 = 1 with data0 = 8'hA5, full = 0:
  - Cycle +1: wr = 1, w_data = A5, ack0 = 1, last_grant = 0.
  - Cycle +2: wr = 0, wr_count = 1.
- req0 and req1 held high continuously, data0 = 8'h11, data1 = 8'h22:
  - w_data sequence is 11, 22, 11, 22 on alternate cycles.
  - ack pulses alternate with no gaps except the IDLE cycle between writes.
- full = 1 while req1 = 1 for 5 cycles, then full = 0:
  - No wr or ack during the 5 cycles.
  - wr = 1 with data1 exactly 1 cycle after full falls.
- Attach a real `fifo` with B = 8, W = 2; no reads; req0 held high:
  - Exactly 4 writes occur and full rises.
  - No fifth wr appears while full = 1.
  - After one FIFO read, exactly one further write occurs.
- C = 3, 9 single-requester writes: wr_count reads 1..7, 0, 1 (wraps 7 -> 0).
- Reset pulsed during WRITE (both reqs high):
  - wr and ack drop within the same cycle; wr_count = 0; last_grant = 1.
  - First grant after release goes to requester 0.
